// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth digit decoder for the MUL unit.
package booth_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef enum logic [2:0] {ZERO, P1, P2, M1, M2} booth_dig_t;

  // Map one overlapping multiplier group {q1,q0,q-1} to a Booth digit.
  function automatic booth_dig_t booth_decode(input logic [2:0] grp);
    booth_dig_t dig;
    case (grp)
      3'b001, 3'b010: dig = P1;
      3'b011:         dig = P2;
      3'b100:         dig = M2;
      3'b101, 3'b110: dig = M1;
      default:        dig = ZERO;
    endcase
    return dig;
  endfunction

endpackage

// File: rtl/booth_r4_pp_sel.sv
// Partial-product selector: turns a Booth digit and the extended multiplicand
// into the signed addend for the accumulator. One bit wider than M so that
// -2M of the most negative multiplicand still fits.
module booth_r4_pp_sel
  import booth_pkg::*;
#(
  parameter int XW = 10
) (
  input  logic [XW-1:0] i_m,
  input  booth_dig_t    i_dig,
  output logic [XW:0]   o_addend
);

  logic [XW:0] w_m1;
  logic [XW:0] w_m2;

  assign w_m1 = {i_m[XW-1], i_m};
  assign w_m2 = {i_m, 1'b0};

  // Select 0, +-M or +-2M.
  always_comb begin
    o_addend = '0;
    case (i_dig)
      P1:      o_addend = w_m1;
      P2:      o_addend = w_m2;
      M1:      o_addend = -w_m1;
      M2:      o_addend = -w_m2;
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_mult_hs.sv
// Radix-4 Booth multiplier with valid/ready on both sides, per-transaction
// signed/unsigned mode and a one-cycle path for zero operands.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for operands, in_ready=1
//   RUN   | one Booth digit per cycle: add, arithmetic shift by 2
//   DONE  | product valid, held until out_ready; may accept next op
module booth_r4_mult_hs
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);

  localparam int XW = W + 2;
  localparam int N  = XW / 2;
  localparam int CW = $clog2(N + 1);
  localparam int TW = 2 * XW + 2;

  generate
    if ((W % 2) != 0 || W < 4) begin : g_bad_w
      $error("booth_r4_mult_hs: W must be even and >= 4");
    end
  endgenerate

  state_t          r_state;
  logic [XW:0]     r_a;
  logic [XW-1:0]   r_q;
  logic            r_qm1;
  logic [XW-1:0]   r_m;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_product;
  logic            r_out_valid;
  logic            r_busy;

  logic            w_accept;
  logic            w_zero;
  logic [1:0]      w_ext_a;
  logic [1:0]      w_ext_b;
  booth_dig_t      w_dig;
  logic [XW:0]     w_addend;
  logic [XW:0]     w_sum;
  logic signed [TW-1:0] w_cat;
  logic [TW-1:0]   w_shift;

  assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_zero    = (op_a == '0) | (op_b == '0);
  assign w_ext_a   = signed_mode ? {2{op_a[W-1]}} : 2'b00;
  assign w_ext_b   = signed_mode ? {2{op_b[W-1]}} : 2'b00;

  assign w_dig     = booth_decode({r_q[1:0], r_qm1});

  booth_r4_pp_sel #(.XW(XW)) u_pp_sel (
    .i_m      (r_m),
    .i_dig    (w_dig),
    .o_addend (w_addend)
  );

  // XW+1-bit two's-complement add, then arithmetic shift of {A,Q,Qm1} by 2.
  assign w_sum     = r_a + w_addend;
  assign w_cat     = {w_sum, r_q, r_qm1};
  assign w_shift   = w_cat >>> 2;

  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign busy      = r_busy;

  // Control FSM and datapath registers; accept takes priority in IDLE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_q         <= '0;
      r_qm1       <= 1'b0;
      r_m         <= '0;
      r_cnt       <= '0;
      r_product   <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_accept) begin
      r_busy <= 1'b1;
      if (w_zero) begin
        r_state     <= DONE;
        r_product   <= '0;
        r_out_valid <= 1'b1;
      end else begin
        r_state     <= RUN;
        r_out_valid <= 1'b0;
        r_m         <= {w_ext_a, op_a};
        r_q         <= {w_ext_b, op_b};
        r_a         <= '0;
        r_qm1       <= 1'b0;
        r_cnt       <= CW'(N);
      end
    end else begin
      case (r_state)
        RUN: begin
          r_a   <= w_shift[TW-1 -: XW+1];
          r_q   <= w_shift[XW:1];
          r_qm1 <= w_shift[0];
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_state     <= DONE;
            r_product   <= w_shift[2*W:1];
            r_out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/booth_r4_mult_hs.md
Name: booth_r4_mult_hs

Overview:
Parametrised radix-4 Booth multiplier, the successor to the fixed 8-bit structural multiplier.
- Adds a valid/ready handshake on input and output.
- Adds a per-transaction signed/unsigned mode and a zero-operand early exit.
- Evaluates, adds and shifts in one cycle per Booth digit, where the fixed 8-bit version used two.
- Sits in the ALU as the multi-cycle MUL unit, fed by the issue stage and drained by writeback.

Parameters:
W, 8, operand width in bits; must be even and >= 4 (elaboration-time check).

Ports:
clk  input  1  clock.
rst  input  1  reset; one clock; reset is synchronous and active-high.
in_valid  input  1  operands presented.
in_ready  output  1  unit can accept operands this cycle.
op_a  input  W  multiplicand.
op_b  input  W  multiplier.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned operands.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
product  output  2W  result, bit pattern of op_a*op_b in the chosen mode.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state = IDLE.
  - product = 0, out_valid = 0, busy = 0.
  - All internal registers are cleared.
  - Reset overrides any in-flight operation, and no output is produced for that operation.
- Derived constants:
  - XW = W+2.
  - N = XW/2 iterations; N = 5 for W = 8.
  - Counter width = $clog2(N+1).
- Operand extension at accept:
  - The extension bits of both operands are {op[W-1],op[W-1]} if signed_mode=1, else 2'b00.
  - The extended multiplicand is M (XW bits).
  - Registers are loaded as A = 0 (XW+1 bits), Q = extended op_b (XW bits), Qm1 = 0, cnt = N.
- States:
  - IDLE: in_ready=1. Accept happens when in_valid & in_ready.
    - If op_a==0 or op_b==0, go to DONE with product = 0 (out_valid one cycle after accept).
    - Otherwise load the registers and go to RUN.
  - RUN: in_ready=0. Each cycle, decode {Q[1],Q[0],Qm1} with the standard radix-4 table.
    - 000 and 111 → 0.
    - 001 and 010 → +M.
    - 011 → +2M.
    - 100 → -2M.
    - 101 and 110 → -M.
    - Compute A' = A + sel using XW+1-bit signed arithmetic, with M sign-extended to XW+1.
    - Then arithmetic-shift {A',Q,Qm1} right by 2 and decrement cnt.
    - When cnt reaches 1 and its iteration completes, go to DONE and register product = {A,Q}[2W-1:0] from the post-shift value.
  - DONE: out_valid=1, and product is held stable while out_ready=0.
    - On out_ready=1: if in_valid=1 the new operands are accepted the same cycle (back-to-back), and the next state follows the IDLE accept rules. Otherwise go to IDLE.
- Handshake signals:
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - in_valid is ignored in RUN.
  - Operands and signed_mode are sampled only at accept; later changes have no effect.
- Latency:
  - Non-zero operands: N cycles from the accept edge to out_valid rising.
  - Zero operand: 1 cycle.
- Product register: holds its last value in IDLE (not cleared after hand-off) and is cleared only by reset.
- The -2M case of the most negative M (signed op_a = -2^(W-1)) is representable because the adder is XW+1 bits, so no overflow occurs.

Decomposition:
- Shared package booth_pkg:
  - state_t enum (IDLE, RUN, DONE).
  - booth_dig_t enum (ZERO, P1, P2, M1, M2).
  - booth_decode function (3-bit group → booth_dig_t).
- Sub-module booth_r4_pp_sel (combinational): inputs M and booth_dig_t, output the XW+1-bit signed addend. Instantiated once.

Test Plan:
- W=8, signed, op_a=7, op_b=3 → product=16'h0015. out_valid rises exactly 5 cycles after accept, and busy is high through RUN and DONE.
- Mode distinction:
  - signed, op_a=8'h80, op_b=8'h80 → 16'h4000.
  - unsigned, op_a=8'hFF, op_b=8'hFF → 16'hFE01.
  - signed, op_a=8'hFF, op_b=8'hFF → 16'h0001.
- Zero exit: op_a=0, op_b=8'h5A (either mode) → product=0 with out_valid 1 cycle after accept. op_a=8'h13, op_b=0 → same response.
- Backpressure and back-to-back:
  - Hold out_ready=0 for 3 cycles in DONE → product and out_valid stable, in_ready=0.
  - Then raise out_ready with in_valid=1 (signed, -5 × 6) → same-cycle accept, next product=16'hFFE2 after 5 cycles.
- Reset mid-op: assert rst 2 cycles into RUN → next cycle state=IDLE, out_valid=0, product=0, in_ready=1, and no stale result appears. A following transaction (signed, 12 × -12) → 16'hFF70.
- Random sweep: 2000 random operands in both modes, for W=8 and W=16, compared against a behavioural $signed/$unsigned product. Latency must always be N, or 1 for a zero operand.
